id_ex_stage: RTL

//  Decode->execute pipeline register. Captures operands from the register file
//  (rs1/rs2 already carry the writeback bypass), applies MEM-stage forwarding,

---
 rtl/id_ex_stage.sv | 94 +++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with MEM-stage operand forwarding,
// load-use hazard bubbling, EX backpressure, flush and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_id_valid,
  output logic             o_id_ready,
  input  logic [XLEN-1:0]  i_id_pc,
  input  logic [31:0]      i_id_instr,
  input  logic [4:0]       i_rs1_addr,
  input  logic [4:0]       i_rs2_addr,
  input  logic             i_rs1_use,
  input  logic             i_rs2_use,
  input  logic [4:0]       i_rd_addr,
  input  logic             i_rd_we,
  input  logic             i_is_load,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic             i_mem_we,
  input  logic [4:0]       i_mem_rd,
  input  logic [XLEN-1:0]  i_mem_res,
  input  logic             i_ex_ready,
  output logic             o_ex_valid,
  output logic [XLEN-1:0]  o_ex_pc,
  output logic [31:0]      o_ex_instr,
  output logic [XLEN-1:0]  o_ex_rs1,
  output logic [XLEN-1:0]  o_ex_rs2,
  output logic [4:0]       o_ex_rd_addr,
  output logic             o_ex_rd_we,
  output logic             o_ex_is_load,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  logic            advance_c;
  logic            hazard_c;
  logic            bubble_c;
  logic            take_c;
  logic [XLEN-1:0] rs1_fwd_c;
  logic [XLEN-1:0] rs2_fwd_c;

  assign advance_c = !o_ex_valid || i_ex_ready;

  // Load in EX whose result is needed by the ID instruction: not yet available.
  assign hazard_c = o_ex_valid && o_ex_is_load && o_ex_rd_we && (o_ex_rd_addr != 5'd0) &&
                    ((i_rs1_use && (i_rs1_addr == o_ex_rd_addr)) ||
                     (i_rs2_use && (i_rs2_addr == o_ex_rd_addr)));

  assign o_id_ready = advance_c && !hazard_c;
  assign bubble_c   = advance_c && !i_flush && hazard_c && i_id_valid;
  assign take_c     = advance_c && !i_flush && !(hazard_c && i_id_valid);

  // x0 is hardwired zero; otherwise MEM result beats register-file data.
  assign rs1_fwd_c = (i_rs1_addr == 5'd0) ? '0 :
                     (i_mem_we && (i_mem_rd == i_rs1_addr)) ? i_mem_res : i_rs1_data;
  assign rs2_fwd_c = (i_rs2_addr == 5'd0) ? '0 :
                     (i_mem_we && (i_mem_rd == i_rs2_addr)) ? i_mem_res : i_rs2_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ex_valid   <= 1'b0;
      o_ex_pc      <= '0;
      o_ex_instr   <= '0;
      o_ex_rs1     <= '0;
      o_ex_rs2     <= '0;
      o_ex_rd_addr <= '0;
      o_ex_rd_we   <= 1'b0;
      o_ex_is_load <= 1'b0;
      o_bubble_cnt <= '0;
    end else begin
      if (i_flush || bubble_c) begin
        o_ex_valid   <= 1'b0;
        o_ex_rd_we   <= 1'b0;
        o_ex_is_load <= 1'b0;
      end else if (take_c) begin
        o_ex_valid   <= i_id_valid;
        o_ex_rd_we   <= i_id_valid && i_rd_we;
        o_ex_is_load <= i_id_valid && i_is_load;
        o_ex_pc      <= i_id_pc;
        o_ex_instr   <= i_id_instr;
        o_ex_rs1     <= rs1_fwd_c;
        o_ex_rs2     <= rs2_fwd_c;
        o_ex_rd_addr <= i_rd_addr;
      end
      if (bubble_c && (o_bubble_cnt != '1)) begin
        o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule
